// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: command, result, key-store and round-datapath signals of aes_round_ctrl.
// Latency: none, wiring only. Backpressure: valid/ready on command and result paths.
// abort_i exists only when AES_ROUND_CTRL_ABORT_EN is defined.
interface aes_round_ctrl_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         decrypt_i;
    logic [127:0] block_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] block_o;
    logic         busy_o;
    logic [3:0]   key_idx_o;
    logic [127:0] key_i;
    logic [127:0] rnd_block_o;
    logic [127:0] rnd_key_o;
    logic         rnd_decrypt_o;
    logic         rnd_last_o;
    logic [127:0] rnd_block_i;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort_i;
`endif

    modport slave (
`ifdef AES_ROUND_CTRL_ABORT_EN
        input  abort_i,
`endif
        input  in_valid_i, decrypt_i, block_i, out_ready_i, key_i, rnd_block_i,
        output in_ready_o, out_valid_o, block_o, busy_o, key_idx_o,
               rnd_block_o, rnd_key_o, rnd_decrypt_o, rnd_last_o
    );

    modport master (
`ifdef AES_ROUND_CTRL_ABORT_EN
        output abort_i,
`endif
        output in_valid_i, decrypt_i, block_i, out_ready_i, key_i, rnd_block_i,
        input  in_ready_o, out_valid_o, block_o, busy_o, key_idx_o,
               rnd_block_o, rnd_key_o, rnd_decrypt_o, rnd_last_o
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES-128 block through 10 passes of a shared round datapath (abort via AES_ROUND_CTRL_ABORT_EN).
// Latency: encrypt 1+10*(ROUND_LAT+1) cycles accept-to-valid, decrypt one cycle more for the final key XOR.
// Backpressure: one block in flight; in_ready only in IDLE, result held in DONE until out_ready.
module aes_round_ctrl #(
    parameter int ROUND_LAT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    localparam logic [3:0] LAT = 4'(ROUND_LAT);

    state_t       state, state_nxt;
    logic [127:0] data, data_nxt;
    logic         decrypt, decrypt_nxt;
    logic [3:0]   pass, pass_nxt;
    logic [3:0]   wait_cnt, wait_nxt;
    logic         abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            data     <= '0;
            decrypt  <= 1'b0;
            pass     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            data     <= data_nxt;
            decrypt  <= decrypt_nxt;
            pass     <= pass_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        data_nxt          = data;
        decrypt_nxt       = decrypt;
        pass_nxt          = pass;
        wait_nxt          = wait_cnt;
        bus.in_ready_o    = 1'b0;
        bus.out_valid_o   = 1'b0;
        bus.block_o       = '0;
        bus.busy_o        = (state != IDLE);
        bus.key_idx_o     = '0;
        bus.rnd_block_o   = '0;
        bus.rnd_key_o     = '0;
        bus.rnd_decrypt_o = 1'b0;
        bus.rnd_last_o    = 1'b0;

        case (state)
            IDLE: begin
                // key_idx_o is 0 here, so key_i is the whitening key
                bus.in_ready_o = !rst_i;
                if (bus.in_valid_i && !rst_i) begin
                    decrypt_nxt = bus.decrypt_i;
                    data_nxt    = bus.decrypt_i ? bus.block_i : (bus.block_i ^ bus.key_i);
                    pass_nxt    = 4'd1;
                    wait_nxt    = 4'd0;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                bus.key_idx_o     = decrypt ? (4'd11 - pass) : pass;
                bus.rnd_block_o   = data;
                bus.rnd_key_o     = bus.key_i;
                bus.rnd_decrypt_o = decrypt;
                bus.rnd_last_o    = decrypt ? (pass == 4'd1) : (pass == 4'd10);
                if (wait_cnt == LAT) begin
                    data_nxt = bus.rnd_block_i;
                    wait_nxt = 4'd0;
                    pass_nxt = pass + 4'd1;
                    if (pass == 4'd10)
                        state_nxt = decrypt ? FINAL : DONE;
                end else begin
                    wait_nxt = wait_cnt + 4'd1;
                end
            end
            FINAL: begin
                data_nxt  = data ^ bus.key_i;
                state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid_o = 1'b1;
                bus.block_o     = data;
                if (bus.out_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // abort overrides everything, including a same-cycle result handshake
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            data_nxt  = '0;
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: models the key store and an L-stage round datapath, checks results
// against a plain FIPS-197 AES-128 model through a scoreboard and a per-cycle key/last schedule.
module tb_aes_round_ctrl;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus();
    aes_round_ctrl #(.ROUND_LAT(L)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [11];

    typedef struct { logic [127:0] data; int t; bit dec; } exp_t;
    exp_t sb[$];

    bit act = 0;
    int act_t = 0;
    bit act_dec = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++)
            y[127-8*i -: 8] = inv ? isbox[x[127-8*i -: 8]] : sbox[x[127-8*i -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int sc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*sc+r) -: 8];
            end
        return y;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] x, input bit inv);
        logic [7:0] m [4];
        logic [7:0] a [4];
        logic [7:0] b;
        logic [127:0] y;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = x[127-8*(4*c+k) -: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gmul(m[(k - r + 4) % 4], a[k]);
                y[127-8*(4*c+r) -: 8] = b;
            end
        end
        return y;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook cipher and inverse cipher
    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r != 10) s = mix_cols(s, 1'b0);
            s ^= rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
            s ^= rk[r];
            if (r != 0) s = mix_cols(s, 1'b1);
        end
        return s;
    endfunction

    // External round datapath: one pass per call, L register stages deep
    function automatic logic [127:0] dp_round(input logic [127:0] s_in, input logic [127:0] k,
                                              input bit dec, input bit last);
        logic [127:0] s;
        s = s_in;
        if (!dec) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (!last) s = mix_cols(s, 1'b0);
            s ^= k;
        end else begin
            s ^= k;
            if (!last) s = mix_cols(s, 1'b1);
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
        end
        return s;
    endfunction

    logic [127:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= dp_round(bus.rnd_block_o, bus.rnd_key_o, bus.rnd_decrypt_o, bus.rnd_last_o);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rnd_block_i = pipe[L-1];
    assign bus.key_i = (bus.key_idx_o <= 4'd10) ? rk[bus.key_idx_o] : '0;

    // Monitor: samples 2ns after the falling edge, when bench inputs for the next rising edge are settled
    bit           prev_vld = 0;
    logic [127:0] prev_blk = '0;
    always @(negedge clk) begin : mon
        int d, p, ei;
        bit el;
        #2;
        if (rst) begin
            prev_vld = 0;
        end else begin
            if (bus.out_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", bus.out_valid_o, 1'b0);
                end else begin
                    if (!prev_vld) begin
                        check("out_latency", cyc - sb[0].t, sb[0].dec ? 2 + 10*(L+1) : 1 + 10*(L+1));
                        check("out_data", bus.block_o, sb[0].data);
                    end else begin
                        check("out_hold", bus.block_o, prev_blk);
                    end
                    if (bus.out_ready_i) void'(sb.pop_front());
                end
            end
            prev_vld = bus.out_valid_o;
            prev_blk = bus.block_o;
            if (act) begin
                d = cyc - act_t;
                if (d >= 1 && d <= 10*(L+1)) begin
                    p  = (d - 1) / (L + 1) + 1;
                    ei = act_dec ? 11 - p : p;
                    el = act_dec ? (p == 1) : (p == 10);
                    check("round_seq",
                          {bus.key_idx_o, bus.rnd_last_o, bus.rnd_decrypt_o, bus.rnd_key_o},
                          {4'(ei), el, act_dec, rk[ei]});
                end else if (d == 10*(L+1) + 1) begin
                    check("post_key_idx", bus.key_idx_o, 4'd0);
                end
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [127:0] blk, input bit dec, input logic [127:0] want);
        int n;
        n = 0;
        bus.block_i = blk; bus.decrypt_i = dec; bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && n < 200) begin @(negedge clk); n++; end
        if (!bus.in_ready_o) begin
            check("accept_timeout", bus.in_ready_o, 1'b1);
        end else begin
            sb.push_back('{want, cyc, dec});
            act = 1; act_t = cyc; act_dec = dec;
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.block_i    = rand128();
        bus.decrypt_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input bit rnd_rdy);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            bus.out_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        act = 0;
        bus.out_ready_i = 1'b1;
    endtask

    task automatic go_to(input int d);
        while (cyc - act_t < d) @(negedge clk);
    endtask

    initial begin : glob_to
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    initial begin : main
        logic [127:0] fkey, fpt, fct, k, b;
        bit dec;
        int n;
        fkey = 128'h000102030405060708090a0b0c0d0e0f;
        fpt  = 128'h00112233445566778899aabbccddeeff;
        fct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        bus.in_valid_i = 1'b0; bus.decrypt_i = 1'b0; bus.block_i = '0; bus.out_ready_i = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
        bus.abort_i = 1'b0;
`endif
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v, p, s;
            v = x[7:0]; p = 8'h01;
            repeat (254) p = gmul(p, v);
            s = p ^ rol(p, 1) ^ rol(p, 2) ^ rol(p, 3) ^ rol(p, 4) ^ 8'h63;
            sbox[x] = s;
            isbox[s] = v;
        end
        expand(fkey);

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready_o, 1'b0);
        check("rst_out_valid", bus.out_valid_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_rnd", {bus.key_idx_o, bus.rnd_last_o, bus.rnd_decrypt_o, bus.rnd_key_o, bus.rnd_block_o}, '0);
        check("rst_block_o", bus.block_o, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready_o, 1'b1);

        issue(fpt, 1'b0, fct);
        wait_done(1'b0);
        issue(fct, 1'b1, fpt);
        wait_done(1'b0);

        for (int i = 0; i < 8; i++) begin
            k = rand128(); b = rand128(); dec = 1'($urandom_range(0, 1));
            expand(k);
            issue(b, dec, dec ? ref_dec(b) : ref_enc(b));
            wait_done(1'b1);
        end

        // Output backpressure with a stray input request
        k = rand128(); b = rand128(); expand(k);
        bus.out_ready_i = 1'b0;
        issue(b, 1'b0, ref_enc(b));
        n = 0;
        while (!bus.out_valid_o && n < 200) begin @(negedge clk); n++; end
        check("bp_valid_seen", bus.out_valid_o, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid_i = 1'b1; bus.block_i = rand128();
            check("bp_in_ready", bus.in_ready_o, 1'b0);
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_vld", bus.out_valid_o, 1'b0);
        check("bp_release_rdy", bus.in_ready_o, 1'b1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        act = 0;

        // Reset in the middle of pass 5
        k = rand128(); b = rand128(); expand(k);
        issue(b, 1'b1, ref_dec(b));
        go_to(4*(L+1) + 3);
        act = 0; sb.delete();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy_o, 1'b0);
        check("mid_rst_in_ready", bus.in_ready_o, 1'b0);
        check("mid_rst_rnd", {bus.key_idx_o, bus.rnd_last_o, bus.rnd_decrypt_o, bus.rnd_key_o, bus.rnd_block_o}, '0);
        check("mid_rst_out", {bus.out_valid_o, bus.block_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        b = rand128();
        issue(b, 1'b0, ref_enc(b));
        wait_done(1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
        b = rand128();
        issue(b, 1'b0, ref_enc(b));
        go_to(2*(L+1) + 3);
        act = 0; sb.delete();
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort_busy", bus.busy_o, 1'b0);
        check("abort_in_ready", bus.in_ready_o, 1'b1);
        repeat (60) @(negedge clk);
        b = rand128();
        issue(b, 1'b0, ref_enc(b));
        wait_done(1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
